rv_decode_execute: RTL and testbench

Combined opcode decoder, ALU-control decoder and 32-bit integer ALU for the RV32I single-cycle datapath. Takes the fetched instruction plus register-file operands and the generated immediate, and produces all datapath control strobes, the ALU result and the branch/jump decision. All outputs are registered for one cycle, giving a clean pipeline boundary between decode/execute and memory/writeback.

---
 rtl/rv_decode_execute.sv | 188 ++++++++++++++++++
 tb/tb_rv_decode_execute.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_execute.sv
// RV32I decode/execute stage: opcode + ALU-control decode, 32-bit ALU and branch
// decision, all outputs registered. Define ALU_SHIFT_EN to build the shifter.
module rv_decode_execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        take,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        link,
  output logic        jalr_base,
  output logic [3:0]  alu_ctrl,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100, ALU_SRL = 4'b0101, ALU_SUB = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0]  w_funct3;
  logic        w_f7b;
  logic        w_alu_src, w_mem_to_reg, w_mem_read, w_mem_write;
  logic        w_branch, w_reg_write, w_link, w_jalr_base, w_illegal;
  logic [1:0]  w_alu_op;
  alu_ctrl_e   w_alu_ctrl;
  logic [31:0] w_op_b;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_take;
  logic        w_unused_bits;

  assign w_funct3      = instr[14:12];
  assign w_f7b         = instr[30];
  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_link       = 1'b0;
    w_jalr_base  = 1'b0;
    w_illegal    = 1'b0;
    w_alu_op     = 2'b00;
    case (instr[6:0])
      OP_R:      begin w_reg_write = 1'b1; w_alu_op = 2'b10; end
      OP_I:      begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b11; end
      OP_LOAD:   begin w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1;
                       w_mem_read = 1'b1; end
      OP_STORE:  begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
      OP_BRANCH: begin w_branch = 1'b1; w_alu_op = 2'b01; end
      OP_JAL:    begin w_branch = 1'b1; w_reg_write = 1'b1; w_link = 1'b1; end
      OP_JALR:   begin w_alu_src = 1'b1; w_branch = 1'b1; w_reg_write = 1'b1;
                       w_link = 1'b1; w_jalr_base = 1'b1; end
      default:   w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_alu_op)
      2'b00: w_alu_ctrl = ALU_ADD;
      2'b01: begin
        case (w_funct3)
          3'b100, 3'b101: w_alu_ctrl = ALU_SLT;
          3'b110, 3'b111: w_alu_ctrl = ALU_SLTU;
          default:        w_alu_ctrl = ALU_SUB;
        endcase
      end
      default: begin
        case (w_funct3)
          // Immediate forms carry a real immediate in bit 30, so only R-type SUBs.
          3'b000:  w_alu_ctrl = (w_alu_op == 2'b10 && w_f7b) ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_ctrl = ALU_SLL;
          3'b010:  w_alu_ctrl = ALU_SLT;
          3'b011:  w_alu_ctrl = ALU_SLTU;
          3'b100:  w_alu_ctrl = ALU_XOR;
          3'b101:  w_alu_ctrl = w_f7b ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_ctrl = ALU_OR;
          default: w_alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  assign w_op_b = w_alu_src ? imm : rs2_data;

  always_comb begin
    w_result = 32'h0;
    case (w_alu_ctrl)
      ALU_AND:  w_result = rs1_data & w_op_b;
      ALU_OR:   w_result = rs1_data | w_op_b;
      ALU_ADD:  w_result = rs1_data + w_op_b;
      ALU_XOR:  w_result = rs1_data ^ w_op_b;
      ALU_SUB:  w_result = rs1_data - w_op_b;
      ALU_SLT:  w_result = {31'b0, $signed(rs1_data) < $signed(w_op_b)};
      ALU_SLTU: w_result = {31'b0, rs1_data < w_op_b};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  w_result = rs1_data << w_op_b[4:0];
      ALU_SRL:  w_result = rs1_data >> w_op_b[4:0];
      ALU_SRA:  w_result = $unsigned($signed(rs1_data) >>> w_op_b[4:0]);
`endif
      default:  w_result = 32'h0;
    endcase
  end

  assign w_zero = (w_result == 32'h0);

  always_comb begin
    w_take = 1'b0;
    if (w_alu_op == 2'b01) begin
      case (w_funct3)
        3'b000:         w_take = w_zero;
        3'b001:         w_take = ~w_zero;
        3'b100, 3'b110: w_take = w_result[0];
        3'b101, 3'b111: w_take = ~w_result[0];
        default:        w_take = 1'b0;
      endcase
    end else if (w_link) begin
      w_take = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= 32'h0;
      zero       <= 1'b0;
      take       <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      reg_write  <= 1'b0;
      alu_op     <= 2'b00;
      link       <= 1'b0;
      jalr_base  <= 1'b0;
      alu_ctrl   <= 4'b0000;
      illegal    <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      alu_result <= w_result;
      zero       <= w_zero;
      take       <= w_take;
      alu_src    <= w_alu_src;
      mem_to_reg <= w_mem_to_reg;
      mem_read   <= w_mem_read;
      mem_write  <= w_mem_write;
      branch     <= w_branch;
      reg_write  <= w_reg_write;
      alu_op     <= w_alu_op;
      link       <= w_link;
      jalr_base  <= w_jalr_base;
      alu_ctrl   <= w_alu_ctrl;
      illegal    <= w_illegal;
    end
  end

endmodule

// File: tb/tb_rv_decode_execute.sv
// Self-checking bench for rv_decode_execute: directed test-plan cases plus random
// instructions compared against an instruction-level reference model.
module tb_rv_decode_execute;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [31:0] instr, rs1_data, rs2_data, imm;
  logic        out_valid, zero, take, alu_src, mem_to_reg, mem_read, mem_write;
  logic        branch, reg_write, link, jalr_base, illegal;
  logic [31:0] alu_result;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_decode_execute dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero), .take(take),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .reg_write(reg_write),
    .alu_op(alu_op), .link(link), .jalr_base(jalr_base),
    .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  typedef struct packed {
    logic        valid, alu_src, mem_to_reg, mem_read, mem_write;
    logic        branch, reg_write, link, jalr_base, illegal;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] res;
    logic        zero, take;
  } exp_t;

  exp_t cur_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
    logic [31:0] fill;
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    return (a >> sh) | fill;
  endfunction

  // Reference model: what the instruction means, stated directly.
  function automatic exp_t model(input logic rs, input logic v, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] r2,
                                 input logic [31:0] im);
    exp_t e;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        lt, ltu, shift_en;
    e = '0;
    if (rs) return e;
    e.valid = v;
    f3 = ins[14:12];
`ifdef ALU_SHIFT_EN
    shift_en = 1'b1;
`else
    shift_en = 1'b0;
`endif
    case (ins[6:0])
      7'b0110011: begin e.reg_write = 1; e.alu_op = 2; end
      7'b0010011: begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 3; end
      7'b0000011: begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.mem_read = 1; end
      7'b0100011: begin e.alu_src = 1; e.mem_write = 1; end
      7'b1100011: begin e.branch = 1; e.alu_op = 1; end
      7'b1101111: begin e.branch = 1; e.reg_write = 1; e.link = 1; end
      7'b1100111: begin e.alu_src = 1; e.branch = 1; e.reg_write = 1; e.link = 1; e.jalr_base = 1; end
      default:    e.illegal = 1;
    endcase
    b   = e.alu_src ? im : r2;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    if (e.alu_op == 0) begin
      e.alu_ctrl = 4'b0010; e.res = a + b;
    end else if (e.alu_op == 1) begin
      case (f3)
        3'b100, 3'b101: begin e.alu_ctrl = 4'b1000; e.res = {31'b0, lt}; end
        3'b110, 3'b111: begin e.alu_ctrl = 4'b1001; e.res = {31'b0, ltu}; end
        default:        begin e.alu_ctrl = 4'b0110; e.res = a - b; end
      endcase
      case (f3)
        3'b000: e.take = (a == b);
        3'b001: e.take = (a != b);
        3'b100: e.take = lt;
        3'b101: e.take = !lt;
        3'b110: e.take = ltu;
        3'b111: e.take = !ltu;
        default: e.take = 0;
      endcase
    end else begin
      case (f3)
        3'b000: if (e.alu_op == 2 && ins[30]) begin e.alu_ctrl = 4'b0110; e.res = a - b; end
                else begin e.alu_ctrl = 4'b0010; e.res = a + b; end
        3'b001: begin e.alu_ctrl = 4'b0100; e.res = shift_en ? a << b[4:0] : 0; end
        3'b010: begin e.alu_ctrl = 4'b1000; e.res = {31'b0, lt}; end
        3'b011: begin e.alu_ctrl = 4'b1001; e.res = {31'b0, ltu}; end
        3'b100: begin e.alu_ctrl = 4'b0011; e.res = a ^ b; end
        3'b101: if (ins[30]) begin e.alu_ctrl = 4'b0111; e.res = shift_en ? sra(a, b[4:0]) : 0; end
                else begin e.alu_ctrl = 4'b0101; e.res = shift_en ? a >> b[4:0] : 0; end
        3'b110: begin e.alu_ctrl = 4'b0001; e.res = a | b; end
        default: begin e.alu_ctrl = 4'b0000; e.res = a & b; end
      endcase
    end
    if (e.link) e.take = 1;
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  task automatic step(input logic rs, input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic [31:0] r2, input logic [31:0] im);
    @(negedge clk);
    rst = rs; in_valid = v; instr = ins; rs1_data = a; rs2_data = r2; imm = im;
    cur_exp = model(rs, v, ins, a, r2, im);
    @(posedge clk);
    #1;
    check("ctrl", {16'h0, out_valid, alu_src, mem_to_reg, mem_read, mem_write, branch,
                   reg_write, link, jalr_base, illegal, alu_op, alu_ctrl},
          {16'h0, cur_exp.valid, cur_exp.alu_src, cur_exp.mem_to_reg, cur_exp.mem_read,
           cur_exp.mem_write, cur_exp.branch, cur_exp.reg_write, cur_exp.link,
           cur_exp.jalr_base, cur_exp.illegal, cur_exp.alu_op, cur_exp.alu_ctrl});
    check("result", alu_result, cur_exp.res);
    check("zero", {31'b0, zero}, {31'b0, cur_exp.zero});
    check("take", {31'b0, take}, {31'b0, cur_exp.take});
  endtask

  logic [6:0] opc_tbl [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000};

  initial begin
    logic [31:0] ins, a, r2, im;
    logic [6:0]  opc;
    rst = 1; in_valid = 0; instr = 0; rs1_data = 0; rs2_data = 0; imm = 0;

    step(1, 1, mk(7'b0110011, 3'b000, 0), 5, 7, 0);
    check("rst_all", {out_valid, alu_result, alu_ctrl}, 32'h0);

    step(0, 1, mk(7'b0110011, 3'b000, 0), 5, 7, 0);
    check("add12", alu_result, 32'd12);
    step(0, 1, mk(7'b0110011, 3'b000, 1), 5, 7, 0);
    check("sub_m2", alu_result, 32'hFFFF_FFFE);
    check("sub_rw", {29'b0, reg_write, alu_op}, 32'b110);
    step(0, 1, mk(7'b0010011, 3'b000, 1), 10, 0, 32'hFFFF_FFFD);
    check("addi7", alu_result, 32'd7);
    check("addi_ctl", {27'b0, alu_src, alu_ctrl}, 32'b1_0010);
    step(0, 1, mk(7'b0000011, 3'b010, 0), 32'h100, 0, 8);
    check("load", alu_result, 32'h108);
    step(0, 1, mk(7'b0100011, 3'b010, 0), 32'h100, 0, 8);
    check("store", {30'b0, mem_write, reg_write}, 32'b10);

    step(0, 1, mk(7'b1100011, 3'b000, 0), 32'hFFFF_FFFF, 1, 0);
    check("beq", {31'b0, take}, 0);
    step(0, 1, mk(7'b1100011, 3'b001, 0), 32'hFFFF_FFFF, 1, 0);
    check("bne", {31'b0, take}, 1);
    step(0, 1, mk(7'b1100011, 3'b100, 0), 32'hFFFF_FFFF, 1, 0);
    check("blt", {31'b0, take}, 1);
    step(0, 1, mk(7'b1100011, 3'b110, 0), 32'hFFFF_FFFF, 1, 0);
    check("bltu", {31'b0, take}, 0);
    step(0, 1, mk(7'b1100011, 3'b111, 0), 32'hFFFF_FFFF, 1, 0);
    check("bgeu", {31'b0, take}, 1);

    step(0, 1, mk(7'b1100111, 3'b000, 0), 32'h40, 0, 4);
    check("jalr", {29'b0, take, link, jalr_base}, 32'b111);
    step(0, 1, mk(7'b0110111, 3'b000, 0), 1, 2, 3);
    check("lui_ill", {30'b0, illegal, reg_write}, 32'b10);

    step(0, 1, mk(7'b0110011, 3'b101, 1), 32'h8000_0000, 4, 0);
`ifdef ALU_SHIFT_EN
    check("sra", alu_result, 32'hF800_0000);
`else
    check("sra", alu_result, 32'h0);
`endif
    step(1, 1, mk(7'b0110011, 3'b000, 0), 5, 7, 0);
    check("rst_mid", {out_valid, reg_write, alu_result[29:0]}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      opc = opc_tbl[$urandom_range(0, 8)];
      if (opc == 7'b0000000) opc = 7'($urandom);
      ins = {$urandom} & 32'hFFFF_FF80 | {25'b0, opc};
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 3))
        0: r2 = a;
        1: r2 = 32'($urandom_range(0, 40));
        default: r2 = $urandom;
      endcase
      im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      step(($urandom_range(0, 49) == 0), 1'($urandom), ins, a, r2, im);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
